// File: rtl/risk_ldst.sv
// risk_ldst: load/store sequencer and tile register file placed in front of risk_mem.
// It accepts one tile command at a time. It drives risk_mem's addr, strides, we and
// dat_w, and holds them for the memory's read or write latency. On a load it captures
// dat_r into a tile register. The register file also has one ALU read port and one
// ALU write port.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only while idle)
//   cmd_store, cmd_reg            direction (1=store) and tile register index
//   cmd_addr, cmd_stride_x/_y     base element address and strides for risk_mem
//   done                          one-cycle pulse when a command completes
//   mem_addr, mem_stride_x/_y     held address/strides to risk_mem
//   mem_we, mem_dat_w, mem_dat_r  write enable, write tile, read tile
//   rf_raddr, rf_rdata            ALU read port, 1-cycle registered latency
//   rf_we, rf_waddr, rf_wdata     ALU write port
module risk_ldst #(
   parameter int unsigned SZ     = 4,
   parameter int unsigned LOGCNT = 5,
   parameter int unsigned BITS   = 18,
   parameter int unsigned NREG   = 4,
   parameter int unsigned RD_LAT = 4,
   parameter int unsigned WR_LAT = 3,
   localparam int unsigned AW    = 10 + LOGCNT,
   localparam int unsigned SW    = AW - 1,
   localparam int unsigned TW    = BITS * SZ * SZ,
   localparam int unsigned RW    = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_store,
   input  logic [RW-1:0] cmd_reg,
   input  logic [AW-1:0] cmd_addr,
   input  logic [SW-1:0] cmd_stride_x,
   input  logic [SW-1:0] cmd_stride_y,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic [SW-1:0] mem_stride_x,
   output logic [SW-1:0] mem_stride_y,
   output logic          mem_we,
   output logic [TW-1:0] mem_dat_w,
   input  logic [TW-1:0] mem_dat_r,
   input  logic [RW-1:0] rf_raddr,
   output logic [TW-1:0] rf_rdata,
   input  logic          rf_we,
   input  logic [RW-1:0] rf_waddr,
   input  logic [TW-1:0] rf_wdata
);

   localparam int unsigned MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int unsigned CW     = $clog2(MAXLAT + 1);

   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          accept;
   logic          ld_wb;
   logic [RW-1:0] reg_q;
   logic [TW-1:0] regs [NREG];
   logic          cmd_ready_nxt, done_nxt, mem_we_nxt;

   // cmd_ready is high exactly when the sequencer is idle.
   assign accept = cmd_valid & cmd_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state. The latency counter runs 0..LAT-1 inside WR/RD.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ld_wb     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = cmd_store ? WR : RD;
               cnt_nxt   = '0;
            end
         end
         WR: begin
            if (cnt == CW'(WR_LAT - 1)) state_nxt = DONE;
            else                        cnt_nxt   = cnt + CW'(1);
         end
         RD: begin
            if (cnt == CW'(RD_LAT - 1)) begin
               state_nxt = DONE;
               ld_wb     = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from the next state, so the flops below hold the current-state values.
   always_comb begin
      cmd_ready_nxt = 1'b0;
      done_nxt      = 1'b0;
      mem_we_nxt    = 1'b0;
      case (state_nxt)
         IDLE:    cmd_ready_nxt = 1'b1;
         WR:      mem_we_nxt    = 1'b1;
         DONE:    done_nxt      = 1'b1;
         default: ;
      endcase
   end

   // Registered handshake/memory outputs. The command fields are captured once, at acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_ready    <= 1'b1;
         done         <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_stride_x <= '0;
         mem_stride_y <= '0;
         mem_dat_w    <= '0;
         reg_q        <= '0;
      end else begin
         cmd_ready <= cmd_ready_nxt;
         done      <= done_nxt;
         mem_we    <= mem_we_nxt;
         if (accept) begin
            mem_addr     <= cmd_addr;
            mem_stride_x <= cmd_stride_x;
            mem_stride_y <= cmd_stride_y;
            reg_q        <= cmd_reg;
            // Pre-edge register value; a same-edge ALU write is not included.
            if (cmd_store) mem_dat_w <= regs[cmd_reg];
         end
      end
   end

   // Tile register file. The load writeback is assigned last, so it wins a same-index conflict.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
         rf_rdata <= '0;
      end else begin
         rf_rdata <= regs[rf_raddr];
         if (rf_we) regs[rf_waddr] <= rf_wdata;
         if (ld_wb) regs[reg_q]    <= mem_dat_r;
      end
   end

endmodule

// File: tb/tb_risk_ldst.sv
// Self-checking bench for risk_ldst. It uses randomized commands and ALU writes, and
// keeps a tile-register model inside the bench.
module tb_risk_ldst;
   localparam int unsigned SZ     = 4;
   localparam int unsigned LOGCNT = 5;
   localparam int unsigned BITS   = 18;
   localparam int unsigned NREG   = 4;
   localparam int unsigned RD_LAT = 4;
   localparam int unsigned WR_LAT = 3;
   localparam int unsigned AW     = 10 + LOGCNT;
   localparam int unsigned SW     = AW - 1;
   localparam int unsigned TW     = BITS * SZ * SZ;
   localparam int unsigned RW     = $clog2(NREG);

   logic          clk, reset;
   logic          cmd_valid, cmd_ready, cmd_store;
   logic [RW-1:0] cmd_reg;
   logic [AW-1:0] cmd_addr;
   logic [SW-1:0] cmd_stride_x, cmd_stride_y;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic [SW-1:0] mem_stride_x, mem_stride_y;
   logic          mem_we;
   logic [TW-1:0] mem_dat_w, mem_dat_r;
   logic [RW-1:0] rf_raddr, rf_waddr;
   logic [TW-1:0] rf_rdata, rf_wdata;
   logic          rf_we;

   logic [TW-1:0] model [NREG];
   int pass_cnt = 0;
   int total    = 0;

   risk_ldst dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
      .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
      .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
      .done(done), .mem_addr(mem_addr),
      .mem_stride_x(mem_stride_x), .mem_stride_y(mem_stride_y),
      .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [TW-1:0] rand_tw();
      logic [TW-1:0] r;
      r = '0;
      for (int i = 0; i < int'((TW + 31) / 32); i++) r = {r[TW-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_rf(input logic [RW-1:0] idx, output logic [TW-1:0] d);
      rf_raddr = idx;
      tick();
      d = rf_rdata;
   endtask

   task automatic alu_write(input logic [RW-1:0] idx, input logic [TW-1:0] val);
      rf_we = 1'b1; rf_waddr = idx; rf_wdata = val;
      tick();
      rf_we = 1'b0;
      model[idx] = val;
   endtask

   // Issue one command from IDLE and observe it until done (bounded). An optional
   // ALU write goes at cycle alu_at (0 = the acceptance edge).
   // Expected register contents follow the rules: the store snapshot excludes a
   // same-edge ALU write, and a load writeback beats an ALU write on the same edge.
   task automatic run_cmd(input logic st, input logic [RW-1:0] r, input logic [AW-1:0] a,
                          input logic [SW-1:0] sx, input logic [SW-1:0] sy,
                          input logic [TW-1:0] rdval, input int alu_at,
                          input logic [RW-1:0] alu_idx, input logic [TW-1:0] alu_val,
                          output int done_cyc, output int ndone, output int we_cnt,
                          output bit addr_ok, output bit dat_ok);
      logic [TW-1:0] snap;
      snap = model[r];
      done_cyc = -1; ndone = 0; we_cnt = 0; addr_ok = 1'b1; dat_ok = 1'b1;
      cmd_valid = 1'b1; cmd_store = st; cmd_reg = r; cmd_addr = a;
      cmd_stride_x = sx; cmd_stride_y = sy;
      rf_we = (alu_at == 0); rf_waddr = alu_idx; rf_wdata = alu_val;
      if (alu_at == 0) model[alu_idx] = alu_val;
      tick();
      cmd_valid = 1'b0; rf_we = 1'b0;
      cmd_addr = ~a; cmd_stride_x = ~sx; cmd_stride_y = ~sy;
      for (int c = 1; c <= 40; c++) begin
         rf_we = (alu_at == c); rf_waddr = alu_idx; rf_wdata = alu_val;
         mem_dat_r = (!st && c == int'(RD_LAT)) ? rdval : rand_tw();
         if (mem_addr !== a || mem_stride_x !== sx || mem_stride_y !== sy) addr_ok = 1'b0;
         if (st && mem_dat_w !== snap) dat_ok = 1'b0;
         if (mem_we === 1'b1) we_cnt++;
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (alu_at == c) model[alu_idx] = alu_val;
         if (!st && c == int'(RD_LAT)) model[r] = rdval;
         tick();
         rf_we = 1'b0;
         if (done_cyc >= 0) break;
      end
   endtask

   task automatic test_reset();
      logic [TW-1:0] d;
      int nd;
      reset = 1'b1;
      tick();
      total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", cmd_ready); else pass_cnt++;
      total++; if (done !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_done_we: got %0b/%0b expected 0/0", done, mem_we); else pass_cnt++;
      total++; if (mem_addr !== '0 || mem_dat_w !== '0 || mem_stride_x !== '0 || mem_stride_y !== '0)
         $display("FAIL reset_mem_bus: got addr %0h dat_w %0h expected 0", mem_addr, mem_dat_w); else pass_cnt++;
      total++; if (rf_rdata !== '0) $display("FAIL reset_rdata: got %0h expected 0", rf_rdata); else pass_cnt++;
      reset = 1'b0;
      tick();
      // Abort a load in its second RD cycle.
      alu_write(2'd2, rand_tw());
      cmd_valid = 1'b1; cmd_store = 1'b0; cmd_reg = 2'd2; cmd_addr = AW'(16'h0055);
      cmd_stride_x = SW'(1); cmd_stride_y = SW'(4);
      rf_raddr = 2'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      total++; if (cmd_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0)
         $display("FAIL midrd_reset_ctl: got ready %0b we %0b done %0b expected 1/0/0", cmd_ready, mem_we, done); else pass_cnt++;
      total++; if (rf_rdata !== '0 || mem_addr !== '0) $display("FAIL midrd_reset_data: got rdata %0h addr %0h expected 0", rf_rdata, mem_addr); else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < int'(NREG); i++) model[i] = '0;
      nd = 0;
      for (int c = 0; c < 8; c++) begin
         if (done === 1'b1) nd++;
         tick();
      end
      total++; if (nd !== 0) $display("FAIL midrd_no_done: got %0d pulses expected 0", nd); else pass_cnt++;
      total++; if (cmd_ready !== 1'b1) $display("FAIL midrd_ready_after: got %0b expected 1", cmd_ready); else pass_cnt++;
      read_rf(2'd2, d);
      total++; if (d !== model[2]) $display("FAIL midrd_reg_cleared: got %0h expected %0h", d, model[2]); else pass_cnt++;
   endtask

   task automatic test_load();
      logic [TW-1:0] a5, d;
      int dc, nd, wc;
      bit aok, dok;
      a5 = {(TW/8){8'hA5}};
      run_cmd(1'b0, 2'd2, AW'(16'h0040), SW'(1), SW'(4), a5, -1, 2'd0, '0, dc, nd, wc, aok, dok);
      total++; if (dc !== int'(RD_LAT) + 1) $display("FAIL load_done_cycle: got %0d expected %0d", dc, RD_LAT + 1); else pass_cnt++;
      total++; if (!aok) $display("FAIL load_addr_held: got changed expected held 0x40"); else pass_cnt++;
      total++; if (wc !== 0) $display("FAIL load_no_we: got %0d we cycles expected 0", wc); else pass_cnt++;
      total++; if (cmd_ready !== 1'b1) $display("FAIL load_ready_after: got %0b expected 1", cmd_ready); else pass_cnt++;
      read_rf(2'd2, d);
      total++; if (d !== a5) $display("FAIL load_reg2: got %0h expected %0h", d, a5); else pass_cnt++;
   endtask

   task automatic test_store();
      logic [TW-1:0] p, q, d;
      int dc, nd, wc;
      bit aok, dok;
      p = rand_tw(); q = rand_tw();
      alu_write(2'd1, p);
      // ALU overwrites reg1 on the acceptance edge; the store must still send P.
      run_cmd(1'b1, 2'd1, AW'(16'h0100), SW'(2), SW'(8), '0, 0, 2'd1, q, dc, nd, wc, aok, dok);
      total++; if (wc !== int'(WR_LAT)) $display("FAIL store_we_cycles: got %0d expected %0d", wc, WR_LAT); else pass_cnt++;
      total++; if (!dok) $display("FAIL store_dat_w: got mismatching data expected %0h", p); else pass_cnt++;
      total++; if (nd !== 1 || dc !== int'(WR_LAT) + 1) $display("FAIL store_done: got %0d pulses at %0d expected 1 at %0d", nd, dc, WR_LAT + 1); else pass_cnt++;
      total++; if (!aok) $display("FAIL store_addr_held: got changed expected held 0x100"); else pass_cnt++;
      total++; if (cmd_ready !== 1'b1 || mem_we !== 1'b0) $display("FAIL store_after: got ready %0b we %0b expected 1/0", cmd_ready, mem_we); else pass_cnt++;
      read_rf(2'd1, d);
      total++; if (d !== q) $display("FAIL store_alu_kept: got %0h expected %0h", d, q); else pass_cnt++;
   endtask

   task automatic test_wb_conflict();
      logic [TW-1:0] d;
      int dc, nd, wc;
      bit aok, dok;
      alu_write(2'd3, rand_tw());
      run_cmd(1'b0, 2'd3, AW'(16'h0200), SW'(1), SW'(1), TW'(2), int'(RD_LAT), 2'd3, TW'(1), dc, nd, wc, aok, dok);
      read_rf(2'd3, d);
      total++; if (d !== TW'(2)) $display("FAIL conflict_same_idx: got %0h expected 2", d); else pass_cnt++;
      alu_write(2'd3, rand_tw());
      run_cmd(1'b0, 2'd3, AW'(16'h0300), SW'(1), SW'(1), TW'(2), int'(RD_LAT), 2'd0, TW'(1), dc, nd, wc, aok, dok);
      read_rf(2'd0, d);
      total++; if (d !== TW'(1)) $display("FAIL conflict_diff_alu: got %0h expected 1", d); else pass_cnt++;
      read_rf(2'd3, d);
      total++; if (d !== TW'(2)) $display("FAIL conflict_diff_load: got %0h expected 2", d); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] aa, ab;
      logic [TW-1:0] va, vb, d;
      int first_b, d1, d2, nd;
      bit we_seen, a_held;
      aa = AW'(16'h0123); ab = AW'(16'h4567);
      va = rand_tw(); vb = rand_tw();
      first_b = -1; d1 = -1; d2 = -1; nd = 0; we_seen = 1'b0; a_held = 1'b1;
      cmd_valid = 1'b1; cmd_store = 1'b0; cmd_reg = 2'd0; cmd_addr = aa;
      cmd_stride_x = SW'(1); cmd_stride_y = SW'(4);
      tick();
      cmd_reg = 2'd1; cmd_addr = ab;
      for (int c = 1; c <= 16; c++) begin
         mem_dat_r = (c <= int'(RD_LAT) + 2) ? va : vb;
         if (mem_we === 1'b1) we_seen = 1'b1;
         if (done === 1'b1) begin
            nd++;
            if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
         end
         if (first_b < 0 && mem_addr === ab) begin
            first_b = c;
            cmd_valid = 1'b0;
         end
         if (first_b < 0 && mem_addr !== aa) a_held = 1'b0;
         tick();
      end
      cmd_valid = 1'b0;
      model[0] = va; model[1] = vb;
      total++; if (first_b !== int'(RD_LAT) + 3) $display("FAIL bp_second_accept: got cycle %0d expected %0d", first_b, RD_LAT + 3); else pass_cnt++;
      total++; if (nd !== 2) $display("FAIL bp_done_count: got %0d expected 2", nd); else pass_cnt++;
      total++; if (d1 !== int'(RD_LAT) + 1 || d2 !== 2 * int'(RD_LAT) + 3)
         $display("FAIL bp_done_cycles: got %0d,%0d expected %0d,%0d", d1, d2, RD_LAT + 1, 2 * RD_LAT + 3); else pass_cnt++;
      total++; if (we_seen || !a_held) $display("FAIL bp_we_addr: got we_seen %0b a_held %0b expected 0/1", we_seen, a_held); else pass_cnt++;
      read_rf(2'd0, d);
      total++; if (d !== va) $display("FAIL bp_reg0: got %0h expected %0h", d, va); else pass_cnt++;
      read_rf(2'd1, d);
      total++; if (d !== vb) $display("FAIL bp_reg1: got %0h expected %0h", d, vb); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [TW-1:0] v, d;
      int dc, nd, wc;
      bit aok, dok;
      v = rand_tw();
      run_cmd(1'b0, 2'd1, AW'(16'h7FFF), SW'(1), SW'(3), v, -1, 2'd0, '0, dc, nd, wc, aok, dok);
      total++; if (!aok) $display("FAIL wrap_addr: got altered address expected 7fff unchanged"); else pass_cnt++;
      total++; if (dc !== int'(RD_LAT) + 1) $display("FAIL wrap_done_cycle: got %0d expected %0d", dc, RD_LAT + 1); else pass_cnt++;
      read_rf(2'd1, d);
      total++; if (d !== v) $display("FAIL wrap_reg1: got %0h expected %0h", d, v); else pass_cnt++;
   endtask

   task automatic test_random();
      logic st;
      logic [RW-1:0] r, ai;
      logic [TW-1:0] d;
      int at, dc, nd, wc;
      bit aok, dok;
      for (int n = 0; n < 24; n++) begin
         st = 1'($urandom);
         r  = RW'($urandom);
         ai = RW'($urandom);
         if ($urandom_range(0, 3) == 0) at = -1;
         else at = int'($urandom_range(0, st ? WR_LAT + 1 : RD_LAT + 1));
         run_cmd(st, r, AW'($urandom), SW'($urandom), SW'($urandom), rand_tw(), at, ai, rand_tw(),
                 dc, nd, wc, aok, dok);
         total++; if (dc !== (st ? int'(WR_LAT) + 1 : int'(RD_LAT) + 1)) $display("FAIL rnd%0d_done_cycle: got %0d store %0b", n, dc, st); else pass_cnt++;
         total++; if (wc !== (st ? int'(WR_LAT) : 0)) $display("FAIL rnd%0d_we_cycles: got %0d store %0b", n, wc, st); else pass_cnt++;
         total++; if (!aok || !dok || nd !== 1) $display("FAIL rnd%0d_hold: got addr_ok %0b dat_ok %0b done %0d expected 1/1/1", n, aok, dok, nd); else pass_cnt++;
         total++; if (cmd_ready !== 1'b1) $display("FAIL rnd%0d_ready: got %0b expected 1", n, cmd_ready); else pass_cnt++;
      end
      for (int i = 0; i < int'(NREG); i++) begin
         read_rf(RW'(i), d);
         total++; if (d !== model[i]) $display("FAIL rnd_reg%0d: got %0h expected %0h", i, d, model[i]); else pass_cnt++;
      end
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_store = 1'b0; cmd_reg = '0; cmd_addr = '0;
      cmd_stride_x = '0; cmd_stride_y = '0; mem_dat_r = '0;
      rf_raddr = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
      for (int i = 0; i < int'(NREG); i++) model[i] = '0;
      test_reset();
      test_load();
      test_store();
      test_wb_conflict();
      test_backpressure();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
